mod_if: RTL

MOD_IF -- requirements
Module: mod_IF

---
 rtl/mod_if_pkg.sv | 20 ++
 rtl/mod_if_if_id_reg.sv | 22 ++
 rtl/mod_if.sv | 104 ++++++++++
 3 files changed

// File: rtl/mod_if_pkg.sv
// mod_if_pkg: shared fetch-stage constants, FSM encoding and the IF/ID payload type.
package mod_if_pkg;
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;
    localparam logic [3:0]  HALT_OPCODE = 4'hF;
    localparam logic [15:0] NOP_INSTR   = 16'h0000;
    localparam logic [15:0] PC_INC      = 16'd2;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        valid;
    } if_id_t;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:12] == HALT_OPCODE;
    endfunction
endpackage

// File: rtl/mod_if_if_id_reg.sv
// if_id_reg: 33-bit IF/ID pipeline register with enable and clear (clear wins).
module if_id_reg
    import mod_if_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   clr,
    input  if_id_t d,
    output if_id_t q
);
    if_id_t r_d, r_q;

    always_comb r_d = clr ? '{NOP_INSTR, 16'h0000, 1'b0} : en ? d : r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_q <= '{NOP_INSTR, 16'h0000, 1'b0};
        else      r_q <= r_d;
    end

    assign q = r_q;
endmodule

// File: rtl/mod_if.sv
// mod_if: instruction fetch stage with stall, redirect, late-response drop and HLT handling.
module mod_if
    import mod_if_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] instruction_out,
    output logic [15:0] pc_out,
    output logic        valid_out,
    output logic        halt
);
    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d, pend_q, pend_d, drop_addr_q, drop_addr_d;
    logic        run_q;
    logic        ifid_en, ifid_clr, got;
    if_id_t      ifid_in, ifid_q;

    // run_q keeps imem_req low until the first edge after reset release
    assign imem_req  = run_q && (state_q == S_FETCH || state_q == S_DROP);
    assign imem_addr = state_q == S_DROP ? drop_addr_q : pc_q;
    assign got       = imem_req && imem_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        drop_addr_d = drop_addr_q;
        ifid_en     = 1'b0;
        ifid_clr    = 1'b0;
        ifid_in     = ifid_q;
        if (redirect) begin
            ifid_clr    = 1'b1;
            pend_d      = NOP_INSTR;
            pc_d        = {redirect_pc[15:1], 1'b0};
            drop_addr_d = imem_addr;
            state_d     = (imem_req && !imem_ready) ? S_DROP : S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (got && stall) begin
                        pend_d  = imem_rdata;
                        pc_d    = pc_q + PC_INC;
                        state_d = S_HOLD;
                    end else if (got) begin
                        ifid_en = 1'b1;
                        ifid_in = '{imem_rdata, pc_q + PC_INC, 1'b1};
                        pc_d    = pc_q + PC_INC;
                        state_d = is_halt(imem_rdata) ? S_HALT : S_FETCH;
                    end else if (!stall) begin
                        ifid_en       = 1'b1;
                        ifid_in.valid = 1'b0;
                    end
                end
                // pc already advanced past the pended word, so pc_q is its PC+2
                S_HOLD: if (!stall) begin
                    ifid_en = 1'b1;
                    ifid_in = '{pend_q, pc_q, 1'b1};
                    state_d = is_halt(pend_q) ? S_HALT : S_FETCH;
                end
                S_DROP: if (imem_ready) state_d = S_FETCH;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            pend_q      <= NOP_INSTR;
            drop_addr_q <= RESET_PC;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            drop_addr_q <= drop_addr_d;
            run_q       <= 1'b1;
        end
    end

    if_id_reg u_if_id (
        .clk (clk),
        .rst (rst),
        .en  (ifid_en),
        .clr (ifid_clr),
        .d   (ifid_in),
        .q   (ifid_q)
    );

    assign instruction_out = ifid_q.instr;
    assign pc_out          = ifid_q.pc;
    assign valid_out       = ifid_q.valid;
    assign halt            = state_q == S_HALT;
endmodule
